// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for branch tracking and resolution
package branch_pkg;

    localparam int BQ_PC_W = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int BTB_ROWS = 64;

    typedef struct packed {
        logic [BQ_PC_W-1:0] pc;
        logic               pred_taken;
        logic [BQ_PC_W-1:0] pred_target;
    } bq_entry_t;

endpackage

// File: rtl/branch_queue_fifo.sv
// rtl/branch_queue_fifo.sv - synchronous FIFO of in-flight branch entries with clear
module branch_queue_fifo
    import branch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = bq_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // The caller guarantees push only when not full and pop only when
    // non-empty; pointers wrap naturally because DEPTH is a power of two.
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Next-state for pointers, occupancy and storage; clear drops everything in flight
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - checks predicted branches at resolve, redirects and trains the predictor
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [DATA_WIDTH-1:0]    push_pc,
    input  logic                     push_pred_taken,
    input  logic [DATA_WIDTH-1:0]    push_pred_target,
    output logic                     push_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic [DATA_WIDTH-1:0]    resolve_target,
    input  logic                     resolve_is_jal,
    input  logic                     flush,
    output logic                     redirect_valid,
    output logic [DATA_WIDTH-1:0]    redirect_pc,
    output logic                     upd_valid,
    output logic [DATA_WIDTH-1:0]    upd_pc,
    output logic [DATA_WIDTH-1:0]    upd_target,
    output logic                     upd_taken,
    output logic                     upd_is_jal,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispredict_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic                  pred_taken;
        logic [DATA_WIDTH-1:0] pred_target;
    } entry_t;

    entry_t          push_entry;
    entry_t          head;
    logic [CW-1:0]   fifo_count;
    logic            queue_empty;
    logic            pop;
    logic            mispredict;
    logic            clr;
    logic            fifo_push;
    logic [DATA_WIDTH-1:0] correct_pc;

    logic                  redirect_valid_q, redirect_valid_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [DATA_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic [DATA_WIDTH-1:0] upd_target_q, upd_target_d;
    logic                  upd_taken_q, upd_taken_d;
    logic                  upd_is_jal_q, upd_is_jal_d;
    logic                  underflow_err_q, underflow_err_d;
    logic [31:0]           branch_count_q, branch_count_d;
    logic [31:0]           mispredict_count_q, mispredict_count_d;

    // Compare the head entry against the resolved outcome and decide what the queue does.
    // push_ready depends only on registered occupancy, so a same-cycle pop cannot admit a push.
    always_comb begin
        push_entry             = '0;
        push_entry.pc          = push_pc;
        push_entry.pred_taken  = push_pred_taken;
        push_entry.pred_target = push_pred_target;

        push_ready  = (fifo_count != CW'(DEPTH));
        queue_empty = (fifo_count == '0);
        pop         = resolve_valid && !queue_empty;
        mispredict  = (head.pred_taken != resolve_taken) ||
                      (head.pred_taken && resolve_taken && (head.pred_target != resolve_target));
        clr         = flush || (pop && mispredict);
        fifo_push   = push_valid && push_ready && !clr;
        correct_pc  = resolve_taken ? resolve_target : head.pc + DATA_WIDTH'(4);
    end

    branch_queue_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Next values of the registered outputs: pulses default low, data holds until the next event
    always_comb begin
        redirect_valid_d   = 1'b0;
        redirect_pc_d      = redirect_pc_q;
        upd_valid_d        = 1'b0;
        upd_pc_d           = upd_pc_q;
        upd_target_d       = upd_target_q;
        upd_taken_d        = upd_taken_q;
        upd_is_jal_d       = upd_is_jal_q;
        underflow_err_d    = underflow_err_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (resolve_valid && queue_empty) begin
            underflow_err_d = 1'b1;
        end

        if (pop) begin
            upd_valid_d    = 1'b1;
            upd_pc_d       = head.pc;
            upd_target_d   = resolve_target;
            upd_taken_d    = resolve_taken;
            upd_is_jal_d   = resolve_is_jal;
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
                // An external flush already redirects fetch, so ours would be stale
                if (!flush) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = correct_pc;
                end
            end
        end
    end

    // Output and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            upd_valid_q        <= 1'b0;
            upd_pc_q           <= '0;
            upd_target_q       <= '0;
            upd_taken_q        <= 1'b0;
            upd_is_jal_q       <= 1'b0;
            underflow_err_q    <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            upd_valid_q        <= upd_valid_d;
            upd_pc_q           <= upd_pc_d;
            upd_target_q       <= upd_target_d;
            upd_taken_q        <= upd_taken_d;
            upd_is_jal_q       <= upd_is_jal_d;
            underflow_err_q    <= underflow_err_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign upd_valid        = upd_valid_q;
    assign upd_pc           = upd_pc_q;
    assign upd_target       = upd_target_q;
    assign upd_taken        = upd_taken_q;
    assign upd_is_jal       = upd_is_jal_q;
    assign count            = fifo_count;
    assign underflow_err    = underflow_err_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic        push_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_is_jal;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jal;
    logic [2:0]  count;
    logic        underflow_err;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int vectors = 0;
    int errors  = 0;
    int exp_br  = 0;
    int exp_mp  = 0;

    branch_resolve_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_ready       (push_ready),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .resolve_is_jal   (resolve_is_jal),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_is_jal       (upd_is_jal),
        .count            (count),
        .underflow_err    (underflow_err),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid       = 1'b0;
        push_pc          = '0;
        push_pred_taken  = 1'b0;
        push_pred_target = '0;
        resolve_valid    = 1'b0;
        resolve_taken    = 1'b0;
        resolve_target   = '0;
        resolve_is_jal   = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        push_valid       = 1'b1;
        push_pc          = pc;
        push_pred_taken  = pt;
        push_pred_target = tgt;
    endtask

    task automatic set_resolve(input logic tk, input logic [31:0] tgt, input logic jal);
        resolve_valid  = 1'b1;
        resolve_taken  = tk;
        resolve_target = tgt;
        resolve_is_jal = jal;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
        vectors++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %b/%h want 0/0", redirect_valid, redirect_pc); end
        vectors++; if (upd_valid !== 1'b0 || upd_pc !== 32'h0 || upd_target !== 32'h0 || upd_taken !== 1'b0 || upd_is_jal !== 1'b0) begin errors++; $display("FAIL reset_upd got %b %h %h %b %b want all 0", upd_valid, upd_pc, upd_target, upd_taken, upd_is_jal); end
        vectors++; if (underflow_err !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin errors++; $display("FAIL reset_counters got %b %0d %0d want 0 0 0", underflow_err, branch_count, mispredict_count); end
    endtask

    task automatic test_correct_predict();
        set_push(32'h100, 1'b1, 32'h200);
        step();
        idle();
        vectors++; if (count !== 3'd1) begin errors++; $display("FAIL cp_push_count got %0d want 1", count); end
        set_resolve(1'b1, 32'h200, 1'b1);
        step();
        idle();
        exp_br++;
        vectors++; if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_target !== 32'h200 || upd_taken !== 1'b1 || upd_is_jal !== 1'b1) begin errors++; $display("FAIL cp_upd got %b %h %h %b %b want 1 100 200 1 1", upd_valid, upd_pc, upd_target, upd_taken, upd_is_jal); end
        vectors++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL cp_redirect got %b want 0", redirect_valid); end
        vectors++; if (branch_count !== 32'(exp_br) || mispredict_count !== 32'(exp_mp) || count !== 3'd0) begin errors++; $display("FAIL cp_counts got br=%0d mp=%0d cnt=%0d want %0d %0d 0", branch_count, mispredict_count, count, exp_br, exp_mp); end
        step();
        vectors++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL cp_upd_pulse got %b want 0", upd_valid); end
    endtask

    task automatic test_mispredict();
        // predicted taken, actually not taken
        set_push(32'h100, 1'b1, 32'h200);
        step();
        idle();
        set_resolve(1'b0, 32'h999, 1'b0);
        step();
        idle();
        exp_br++; exp_mp++;
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL mp_nt_redirect got %b/%h want 1/104", redirect_valid, redirect_pc); end
        vectors++; if (mispredict_count !== 32'(exp_mp) || branch_count !== 32'(exp_br) || upd_taken !== 1'b0) begin errors++; $display("FAIL mp_nt_counts got mp=%0d br=%0d tk=%b want %0d %0d 0", mispredict_count, branch_count, upd_taken, exp_mp, exp_br); end
        step();
        vectors++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mp_redirect_pulse got %b want 0", redirect_valid); end
        // both taken, wrong target
        set_push(32'h300, 1'b1, 32'h400);
        step();
        idle();
        set_resolve(1'b1, 32'h500, 1'b0);
        step();
        idle();
        exp_br++; exp_mp++;
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500 || mispredict_count !== 32'(exp_mp)) begin errors++; $display("FAIL mp_target got %b/%h mp=%0d want 1/500 %0d", redirect_valid, redirect_pc, mispredict_count, exp_mp); end
        // predicted taken at the top of the address space, fall-through wraps to 0
        set_push(32'hFFFF_FFFC, 1'b1, 32'h40);
        step();
        idle();
        set_resolve(1'b0, 32'h0, 1'b0);
        step();
        idle();
        exp_br++; exp_mp++;
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin errors++; $display("FAIL mp_wrap got %b/%h want 1/0", redirect_valid, redirect_pc); end
        // predicted not-taken, actually taken
        set_push(32'h600, 1'b0, 32'h0);
        step();
        idle();
        set_resolve(1'b1, 32'h640, 1'b0);
        step();
        idle();
        exp_br++; exp_mp++;
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h640 || mispredict_count !== 32'(exp_mp)) begin errors++; $display("FAIL mp_nt_to_t got %b/%h mp=%0d want 1/640 %0d", redirect_valid, redirect_pc, mispredict_count, exp_mp); end
        // not-taken predicted and resolved, differing target ignored
        set_push(32'h700, 1'b0, 32'h123);
        step();
        idle();
        set_resolve(1'b0, 32'h456, 1'b0);
        step();
        idle();
        exp_br++;
        vectors++; if (redirect_valid !== 1'b0 || upd_valid !== 1'b1 || mispredict_count !== 32'(exp_mp)) begin errors++; $display("FAIL nt_correct got rd=%b upd=%b mp=%0d want 0 1 %0d", redirect_valid, upd_valid, mispredict_count, exp_mp); end
    endtask

    task automatic test_squash_younger();
        set_push(32'h10, 1'b0, 32'h0); step();
        set_push(32'h20, 1'b0, 32'h0); step();
        set_push(32'h30, 1'b0, 32'h0); step();
        idle();
        vectors++; if (count !== 3'd3) begin errors++; $display("FAIL sq_fill got %0d want 3", count); end
        set_resolve(1'b1, 32'h80, 1'b0);
        set_push(32'h40, 1'b1, 32'h44);
        step();
        idle();
        exp_br++; exp_mp++;
        vectors++; if (count !== 3'd0 || push_ready !== 1'b1) begin errors++; $display("FAIL sq_count got %0d rdy=%b want 0 1", count, push_ready); end
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || upd_pc !== 32'h10) begin errors++; $display("FAIL sq_redirect got %b/%h upd_pc=%h want 1/80 10", redirect_valid, redirect_pc, upd_pc); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            step();
        end
        idle();
        vectors++; if (count !== 3'd4 || push_ready !== 1'b0) begin errors++; $display("FAIL full got cnt=%0d rdy=%b want 4 0", count, push_ready); end
        set_push(32'h2000, 1'b0, 32'h0);
        step();
        idle();
        vectors++; if (count !== 3'd4) begin errors++; $display("FAIL full_push_ignored got %0d want 4", count); end
        set_push(32'h3000, 1'b0, 32'h0);
        set_resolve(1'b0, 32'h0, 1'b0);
        step();
        idle();
        exp_br++;
        vectors++; if (count !== 3'd3 || upd_pc !== 32'h1000 || redirect_valid !== 1'b0) begin errors++; $display("FAIL full_push_pop got cnt=%0d pc=%h rd=%b want 3 1000 0", count, upd_pc, redirect_valid); end
        for (int i = 1; i < 4; i++) begin
            set_resolve(1'b0, 32'h0, 1'b0);
            step();
            exp_br++;
            vectors++; if (upd_valid !== 1'b1 || upd_pc !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL b2b_%0d got upd=%b pc=%h want 1 %h", i, upd_valid, upd_pc, 32'h1000 + 32'(4 * i)); end
        end
        idle();
        vectors++; if (count !== 3'd0 || branch_count !== 32'(exp_br) || underflow_err !== 1'b0) begin errors++; $display("FAIL b2b_drain got cnt=%0d br=%0d uf=%b want 0 %0d 0", count, branch_count, underflow_err, exp_br); end
    endtask

    task automatic test_underflow();
        step();
        set_resolve(1'b1, 32'h55, 1'b0);
        step();
        idle();
        vectors++; if (underflow_err !== 1'b1 || upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL uf got uf=%b upd=%b rd=%b want 1 0 0", underflow_err, upd_valid, redirect_valid); end
        vectors++; if (branch_count !== 32'(exp_br) || count !== 3'd0) begin errors++; $display("FAIL uf_counts got br=%0d cnt=%0d want %0d 0", branch_count, count, exp_br); end
        step(); step();
        vectors++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", underflow_err); end
    endtask

    task automatic test_flush();
        set_push(32'h500, 1'b1, 32'h600);
        step();
        idle();
        set_resolve(1'b0, 32'h0, 1'b0);
        set_push(32'h700, 1'b1, 32'h800);
        flush = 1'b1;
        step();
        idle();
        exp_br++; exp_mp++;
        vectors++; if (upd_valid !== 1'b1 || upd_pc !== 32'h500 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_upd got upd=%b pc=%h rd=%b want 1 500 0", upd_valid, upd_pc, redirect_valid); end
        vectors++; if (count !== 3'd0 || mispredict_count !== 32'(exp_mp) || branch_count !== 32'(exp_br)) begin errors++; $display("FAIL flush_counts got cnt=%0d mp=%0d br=%0d want 0 %0d %0d", count, mispredict_count, branch_count, exp_mp, exp_br); end
        set_push(32'h900, 1'b0, 32'h0); step();
        set_push(32'h904, 1'b0, 32'h0); step();
        idle();
        flush = 1'b1;
        step();
        idle();
        vectors++; if (count !== 3'd0 || upd_valid !== 1'b0) begin errors++; $display("FAIL flush_only got cnt=%0d upd=%b want 0 0", count, upd_valid); end
    endtask

    task automatic test_reset_mid();
        set_push(32'hA00, 1'b1, 32'hB00); step();
        set_push(32'hA04, 1'b1, 32'hB00); step();
        idle();
        set_resolve(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        idle();
        rst = 1'b0;
        vectors++; if (count !== 3'd0 || upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got cnt=%0d upd=%b rd=%b want 0 0 0", count, upd_valid, redirect_valid); end
        vectors++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || underflow_err !== 1'b0 || upd_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_state got br=%0d mp=%0d uf=%b pc=%h want 0 0 0 0", branch_count, mispredict_count, underflow_err, upd_pc); end
        step();
        vectors++; if (count !== 3'd0 || push_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after got cnt=%0d rdy=%b want 0 1", count, push_ready); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_correct_predict();
        test_mispredict();
        test_squash_younger();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
